ct_mmu_sysmap_lookup: RTL

- Parametrised, pipelined system-memory-map lookup unit for the MMU.
- Holds ENTRY_NUM programmable region upper bounds with per-entry attributes.
- Each region spans from the previous entry's upper bound (or 0 for entry 0) up to, but not including, its own upper bound.
- Accepts physical page addresses over a valid/ready handshake and returns hit, index and attributes two cycles later. Replaces the single-entry combinational hit cell with N chained comparators, config storage, multi-hit detection and back-pressure.

---
 rtl/ct_mmu_sysmap_lookup.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ct_mmu_sysmap_lookup.sv
// System memory map lookup: ENTRY_NUM programmable regions, each [top[i-1], top[i]), with per-entry attributes.
// Latency: a request accepted at edge T has its response registered at edge T+1 (2-stage pipeline, one lookup/cycle).
// Backpressure: resp_rdy low freezes S2; S1 keeps re-comparing against live config; req_rdy drops once both stages are full.
module ct_mmu_sysmap_lookup #(
    parameter int ENTRY_NUM  = 8,
    parameter int PA_WIDTH   = 28,
    parameter int ATTR_WIDTH = 5,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  cfg_wen,
    input  logic [IDX_WIDTH-1:0]  cfg_idx,
    input  logic [PA_WIDTH-1:0]   cfg_top,
    input  logic [ATTR_WIDTH-1:0] cfg_attr,
    input  logic                  cfg_dflt_attr_wen,
    input  logic [ATTR_WIDTH-1:0] cfg_dflt_attr,
    input  logic                  sysmap_en,
    input  logic                  req_vld,
    input  logic [PA_WIDTH-1:0]   req_addr,
    output logic                  req_rdy,
    output logic                  resp_vld,
    input  logic                  resp_rdy,
    output logic                  resp_hit,
    output logic [IDX_WIDTH-1:0]  resp_idx,
    output logic [ATTR_WIDTH-1:0] resp_attr,
    output logic                  resp_multi_hit
);

    typedef struct packed {
        logic                  hit;
        logic [IDX_WIDTH-1:0]  idx;
        logic [ATTR_WIDTH-1:0] attr;
        logic                  multi;
    } resp_t;

    logic [PA_WIDTH-1:0]   top_q  [ENTRY_NUM];
    logic [ATTR_WIDTH-1:0] attr_q [ENTRY_NUM];
    logic [ATTR_WIDTH-1:0] dflt_attr_q;

    logic                  s1_vld;
    logic [PA_WIDTH-1:0]   s1_addr;
    logic                  s2_vld;
    resp_t                 s2_res;
    resp_t                 s1_res;

    logic [ENTRY_NUM-1:0]  ge_bot;
    logic [ENTRY_NUM-1:0]  lt_top;
    logic [ENTRY_NUM-1:0]  s1_hit;

    logic                  s1_adv;
    logic                  s2_adv;

    // Config storage; out-of-range indices are dropped silently.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                top_q[i]  <= '0;
                attr_q[i] <= '0;
            end
            dflt_attr_q <= '0;
        end else begin
            if (cfg_wen && (32'(cfg_idx) < ENTRY_NUM)) begin
                top_q[cfg_idx]  <= cfg_top;
                attr_q[cfg_idx] <= cfg_attr;
            end
            if (cfg_dflt_attr_wen) begin
                dflt_attr_q <= cfg_dflt_attr;
            end
        end
    end

    // Chained comparators: entry i's lower bound is entry i-1's upper bound.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_cmp
            if (gi == 0) begin : g_first
                assign ge_bot[gi] = 1'b1;
            end else begin : g_rest
                assign ge_bot[gi] = (s1_addr >= top_q[gi-1]);
            end
            assign lt_top[gi] = (s1_addr < top_q[gi]);
        end
    endgenerate

    assign s1_hit = ge_bot & lt_top & {ENTRY_NUM{sysmap_en}};

    // Lowest-index priority; more than one set bit flags a misprogrammed map.
    always_comb begin
        s1_res       = '0;
        s1_res.hit   = |s1_hit;
        s1_res.multi = |(s1_hit & (s1_hit - ENTRY_NUM'(1)));
        s1_res.attr  = dflt_attr_q;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                s1_res.idx  = IDX_WIDTH'(i);
                s1_res.attr = attr_q[i];
            end
        end
    end

    assign s2_adv  = !s2_vld || resp_rdy;
    assign s1_adv  = !s1_vld || s2_adv;
    assign req_rdy = s1_adv;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s2_vld  <= 1'b0;
            s2_res  <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld <= req_vld;
                if (req_vld) begin
                    s1_addr <= req_addr;
                end
            end
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_res <= s1_res;
                end
            end
        end
    end

    assign resp_vld       = s2_vld;
    assign resp_hit       = s2_res.hit;
    assign resp_idx       = s2_res.idx;
    assign resp_attr      = s2_res.attr;
    assign resp_multi_hit = s2_res.multi;

endmodule
